// File: rtl/psum_pass_scheduler_if.sv
// Handshake bundle between the pass scheduler and the weight loader, feeder,
// systolic-array monitor and partial-sum accumulator.
interface psum_pass_scheduler_if #(
    parameter int MEM_DEPTH    = 256,
    parameter int MAX_PASSES   = 256,
    parameter int MATRIX_B_COL = 4
);
    localparam int PC_W = $clog2(MAX_PASSES + 1);
    localparam int WC_W = $clog2(MEM_DEPTH + 1);
    localparam int PI_W = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1;

    logic                    cfg_valid_i;
    logic                    cfg_ready_o;
    logic [PC_W-1:0]         cfg_num_passes_i;
    logic [WC_W-1:0]         cfg_num_windows_i;
    logic                    cfg_err_o;
    logic                    wgt_req_o;
    logic [PI_W-1:0]         wgt_pass_idx_o;
    logic                    wgt_ack_i;
    logic                    feed_go_o;
    logic [MATRIX_B_COL-1:0] sa_valid_monitor_i;
    logic                    acc_start_o;
    logic                    acc_first_pass_o;
    logic                    acc_last_pass_o;
    logic                    busy_o;
    logic                    layer_done_o;

    modport master (
        input  cfg_valid_i, cfg_num_passes_i, cfg_num_windows_i, wgt_ack_i, sa_valid_monitor_i,
        output cfg_ready_o, cfg_err_o, wgt_req_o, wgt_pass_idx_o, feed_go_o,
               acc_start_o, acc_first_pass_o, acc_last_pass_o, busy_o, layer_done_o
    );

    modport slave (
        output cfg_valid_i, cfg_num_passes_i, cfg_num_windows_i, wgt_ack_i, sa_valid_monitor_i,
        input  cfg_ready_o, cfg_err_o, wgt_req_o, wgt_pass_idx_o, feed_go_o,
               acc_start_o, acc_first_pass_o, acc_last_pass_o, busy_o, layer_done_o
    );
endinterface

// File: rtl/psum_pass_scheduler.sv
// Sequences channel-tiled convolution passes: weight load, feeder launch, window
// counting and accumulator first/last-pass flag control with a drain guard.
module psum_pass_scheduler #(
    parameter int MEM_DEPTH    = 256,
    parameter int MAX_PASSES   = 256,
    parameter int MATRIX_A_ROW = 4,
    parameter int MATRIX_B_COL = 4,
    parameter int DRAIN_CYCLES = MATRIX_A_ROW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_async_n_i,
    psum_pass_scheduler_if.master bus
);
    localparam int PC_W = $clog2(MAX_PASSES + 1);
    localparam int WC_W = $clog2(MEM_DEPTH + 1);
    localparam int PI_W = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1;
    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_LOAD_W = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] num_passes_q, num_passes_d;
    logic [WC_W-1:0] num_windows_q, num_windows_d;
    logic [PC_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [WC_W-1:0] win_cnt_q, win_cnt_d;
    logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
    logic            mon_prev_q, mon_prev_d;
    logic            cfg_ready_q, cfg_ready_d;
    logic            cfg_err_q, cfg_err_d;
    logic            wgt_req_q, wgt_req_d;
    logic [PI_W-1:0] wgt_idx_q, wgt_idx_d;
    logic            feed_go_q, feed_go_d;
    logic            acc_start_q, acc_start_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            mon_last_s;
    logic            mon_fall_s;
    logic            cfg_ok_s;
    logic            pass_last_s;
    logic [WC_W-1:0] win_inc_s;
    logic            unused_mon_s;

    // Only the last column marks window completion; other columns are observed but unused.
    assign mon_last_s   = bus.sa_valid_monitor_i[MATRIX_B_COL-1];
    assign unused_mon_s = ^bus.sa_valid_monitor_i;
    assign mon_fall_s   = mon_prev_q & ~mon_last_s;
    assign win_inc_s    = win_cnt_q + WC_W'(1);
    assign pass_last_s  = ((pass_cnt_q + PC_W'(1)) == num_passes_q);
    assign cfg_ok_s     = (bus.cfg_num_passes_i  != {PC_W{1'b0}}) &&
                          (bus.cfg_num_passes_i  <= PC_W'(MAX_PASSES)) &&
                          (bus.cfg_num_windows_i != {WC_W{1'b0}}) &&
                          (bus.cfg_num_windows_i <= WC_W'(MEM_DEPTH));

    // Next-state and next-output computation; outputs are loaded one cycle ahead of their state.
    always_comb begin
        state_d       = state_q;
        num_passes_d  = num_passes_q;
        num_windows_d = num_windows_q;
        pass_cnt_d    = pass_cnt_q;
        win_cnt_d     = win_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        cfg_ready_d   = cfg_ready_q;
        wgt_req_d     = wgt_req_q;
        wgt_idx_d     = wgt_idx_q;
        first_d       = first_q;
        last_d        = last_q;
        busy_d        = busy_q;
        cfg_err_d     = 1'b0;
        feed_go_d     = 1'b0;
        acc_start_d   = 1'b0;
        done_d        = 1'b0;
        // Edge history is wiped in START so a stale high never yields a counted edge.
        mon_prev_d    = (state_q == S_START) ? 1'b0 : mon_last_s;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid_i && cfg_ready_q) begin
                    if (cfg_ok_s) begin
                        num_passes_d  = bus.cfg_num_passes_i;
                        num_windows_d = bus.cfg_num_windows_i;
                        pass_cnt_d    = {PC_W{1'b0}};
                        cfg_ready_d   = 1'b0;
                        busy_d        = 1'b1;
                        acc_start_d   = 1'b1;
                        first_d       = 1'b1;
                        last_d        = (bus.cfg_num_passes_i == PC_W'(1));
                        state_d       = S_START;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else begin
                    cfg_ready_d = 1'b1;
                end
            end
            S_START: begin
                win_cnt_d = {WC_W{1'b0}};
                wgt_req_d = 1'b1;
                wgt_idx_d = pass_cnt_q[PI_W-1:0];
                state_d   = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (bus.wgt_ack_i) begin
                    wgt_req_d = 1'b0;
                    feed_go_d = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    wgt_req_d = 1'b1;
                end
            end
            S_RUN: begin
                if (mon_fall_s) begin
                    win_cnt_d = win_inc_s;
                    if (win_inc_s == num_windows_q) begin
                        drain_cnt_d = {DC_W{1'b0}};
                        state_d     = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Flags change only here, after the last skewed row write has committed.
                if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) begin
                    if (pass_last_s) begin
                        done_d      = 1'b1;
                        first_d     = 1'b0;
                        last_d      = 1'b0;
                        busy_d      = 1'b0;
                        cfg_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        pass_cnt_d  = pass_cnt_q + PC_W'(1);
                        acc_start_d = 1'b1;
                        first_d     = 1'b0;
                        last_d      = ((pass_cnt_q + PC_W'(2)) == num_passes_q);
                        state_d     = S_START;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + DC_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                cfg_ready_d = 1'b1;
                busy_d      = 1'b0;
                wgt_req_d   = 1'b0;
                first_d     = 1'b0;
                last_d      = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q       <= S_IDLE;
            num_passes_q  <= {PC_W{1'b0}};
            num_windows_q <= {WC_W{1'b0}};
            pass_cnt_q    <= {PC_W{1'b0}};
            win_cnt_q     <= {WC_W{1'b0}};
            drain_cnt_q   <= {DC_W{1'b0}};
            mon_prev_q    <= 1'b0;
            cfg_ready_q   <= 1'b1;
            cfg_err_q     <= 1'b0;
            wgt_req_q     <= 1'b0;
            wgt_idx_q     <= {PI_W{1'b0}};
            feed_go_q     <= 1'b0;
            acc_start_q   <= 1'b0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_passes_q  <= num_passes_d;
            num_windows_q <= num_windows_d;
            pass_cnt_q    <= pass_cnt_d;
            win_cnt_q     <= win_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            mon_prev_q    <= mon_prev_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_err_q     <= cfg_err_d;
            wgt_req_q     <= wgt_req_d;
            wgt_idx_q     <= wgt_idx_d;
            feed_go_q     <= feed_go_d;
            acc_start_q   <= acc_start_d;
            first_q       <= first_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.cfg_ready_o      = cfg_ready_q;
    assign bus.cfg_err_o        = cfg_err_q;
    assign bus.wgt_req_o        = wgt_req_q;
    assign bus.wgt_pass_idx_o   = wgt_idx_q;
    assign bus.feed_go_o        = feed_go_q;
    assign bus.acc_start_o      = acc_start_q;
    assign bus.acc_first_pass_o = first_q;
    assign bus.acc_last_pass_o  = last_q;
    assign bus.busy_o           = busy_q;
    assign bus.layer_done_o     = done_q;
endmodule

// File: tb/tb_psum_pass_scheduler.sv
// Randomized self-checking bench for psum_pass_scheduler; expectations come from
// per-pass rules (flag pattern, tile index, drain latency) evaluated in the bench.
`timescale 1ns/1ps
module tb_psum_pass_scheduler;
    localparam int MEM_DEPTH    = 256;
    localparam int MAX_PASSES   = 256;
    localparam int MATRIX_A_ROW = 4;
    localparam int MATRIX_B_COL = 4;
    localparam int DRAIN        = MATRIX_A_ROW + 1;
    localparam int PC_W         = $clog2(MAX_PASSES + 1);
    localparam int WC_W         = $clog2(MEM_DEPTH + 1);

    logic clk_i = 1'b0;
    logic rst_async_n_i = 1'b0;
    logic mon_last = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   dn0;

    psum_pass_scheduler_if #(.MEM_DEPTH(MEM_DEPTH), .MAX_PASSES(MAX_PASSES),
                             .MATRIX_B_COL(MATRIX_B_COL)) bus ();

    psum_pass_scheduler #(
        .MEM_DEPTH(MEM_DEPTH), .MAX_PASSES(MAX_PASSES),
        .MATRIX_A_ROW(MATRIX_A_ROW), .MATRIX_B_COL(MATRIX_B_COL)
    ) dut (
        .clk_i(clk_i), .rst_async_n_i(rst_async_n_i), .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (bus.layer_done_o) done_cnt++;
        if (bus.cfg_err_o) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [31:0] m;
        @(posedge clk_i);
        #1;
        m = $urandom;
        m[MATRIX_B_COL-1] = mon_last;
        bus.sa_valid_monitor_i = m[MATRIX_B_COL-1:0];
    endtask

    task automatic set_mon(input logic v);
        mon_last = v;
        bus.sa_valid_monitor_i[MATRIX_B_COL-1] = v;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.cfg_ready_o), 32'd1);
        check_eq({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check_eq({tag, "_start"}, 32'(bus.acc_start_o), 32'd0);
        check_eq({tag, "_wreq"}, 32'(bus.wgt_req_o), 32'd0);
        check_eq({tag, "_flags"}, 32'({bus.acc_first_pass_o, bus.acc_last_pass_o}), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.layer_done_o), 32'd0);
        check_eq({tag, "_feed"}, 32'(bus.feed_go_o), 32'd0);
    endtask

    task automatic bad_cfg(input int np, input int nw, input string tag);
        bus.cfg_num_passes_i  = PC_W'(np);
        bus.cfg_num_windows_i = WC_W'(nw);
        bus.cfg_valid_i = 1'b1;
        tick();
        bus.cfg_valid_i = 1'b0;
        check_eq({tag, "_err"}, 32'(bus.cfg_err_o), 32'd1);
        check_eq({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check_eq({tag, "_start"}, 32'(bus.acc_start_o), 32'd0);
        tick();
        check_eq({tag, "_err_width"}, 32'(bus.cfg_err_o), 32'd0);
        check_idle(tag);
    endtask

    task automatic run_layer(input int np, input int nw, input int ack_force);
        int  d;
        int  fall_c;
        int  at;
        bit  got;
        int  d0;
        int  e0;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 64 && !bus.cfg_ready_o; i++) tick();
        check_eq("cfg_ready", 32'(bus.cfg_ready_o), 32'd1);
        bus.cfg_num_passes_i  = PC_W'(np);
        bus.cfg_num_windows_i = WC_W'(nw);
        bus.cfg_valid_i = 1'b1;
        tick();
        bus.cfg_valid_i = 1'b0;
        for (int p = 0; p < np; p++) begin
            check_eq("acc_start", 32'(bus.acc_start_o), 32'd1);
            check_eq("busy", 32'(bus.busy_o), 32'd1);
            check_eq("first_flag", 32'(bus.acc_first_pass_o), 32'(p == 0));
            check_eq("last_flag", 32'(bus.acc_last_pass_o), 32'(p == np - 1));
            tick();
            check_eq("start_width", 32'(bus.acc_start_o), 32'd0);
            check_eq("wgt_req", 32'(bus.wgt_req_o), 32'd1);
            check_eq("wgt_idx", 32'(bus.wgt_pass_idx_o), 32'(p));
            d = (ack_force >= 0) ? ack_force : int'($urandom_range(0, 3));
            for (int i = 0; i < d; i++) begin
                if (i == 1) begin
                    bus.cfg_num_passes_i = PC_W'(0);
                    bus.cfg_valid_i = 1'b1;
                end else begin
                    bus.cfg_valid_i = 1'b0;
                end
                set_mon((d >= 4) && (i < d - 2) && (i % 2 == 0));
                tick();
                check_eq("wgt_req_hold", 32'(bus.wgt_req_o), 32'd1);
            end
            bus.cfg_valid_i = 1'b0;
            set_mon(1'b0);
            bus.wgt_ack_i = 1'b1;
            tick();
            bus.wgt_ack_i = 1'b0;
            check_eq("feed_go", 32'(bus.feed_go_o), 32'd1);
            check_eq("wgt_req_drop", 32'(bus.wgt_req_o), 32'd0);
            fall_c = cyc;
            for (int w = 0; w < nw; w++) begin
                set_mon(1'b1);
                repeat ($urandom_range(1, 3)) tick();
                set_mon(1'b0);
                fall_c = cyc;
                if (w != nw - 1) repeat ($urandom_range(1, 2)) tick();
            end
            got = 1'b0;
            at = cyc;
            for (int i = 0; i < 64 && !got; i++) begin
                tick();
                if (bus.acc_start_o || bus.layer_done_o) begin
                    got = 1'b1;
                    at = cyc;
                end else begin
                    check_eq("flags_held", 32'({bus.acc_first_pass_o, bus.acc_last_pass_o}),
                             32'({p == 0, p == np - 1}));
                end
            end
            check_eq("pass_end_seen", 32'(got), 32'd1);
            check_eq("pass_end_latency", 32'(at - fall_c), 32'(DRAIN + 1));
            if (p == np - 1) begin
                check_eq("layer_done", 32'(bus.layer_done_o), 32'd1);
                check_eq("no_extra_start", 32'(bus.acc_start_o), 32'd0);
            end else begin
                check_eq("no_early_done", 32'(bus.layer_done_o), 32'd0);
            end
        end
        tick();
        check_idle("post_layer");
        check_eq("done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("busy_cfg_ignored", 32'(err_cnt - e0), 32'd0);
    endtask

    initial begin
        bus.cfg_valid_i        = 1'b0;
        bus.cfg_num_passes_i   = '0;
        bus.cfg_num_windows_i  = '0;
        bus.wgt_ack_i          = 1'b0;
        bus.sa_valid_monitor_i = '0;
        repeat (3) tick();
        check_idle("reset");
        check_eq("reset_err", 32'(bus.cfg_err_o), 32'd0);
        rst_async_n_i = 1'b1;
        tick();
        check_idle("post_reset");

        run_layer(3, 4, -1);
        run_layer(1, 1, -1);
        bad_cfg(0, 4, "zero_passes");
        bad_cfg(2, MEM_DEPTH + 1, "big_windows");
        bad_cfg(MAX_PASSES + 1, 2, "big_passes");
        bad_cfg(1, 0, "zero_windows");
        run_layer(2, 3, 10);
        repeat (4) run_layer(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), -1);
        run_layer(2, MEM_DEPTH, -1);

        // Reset in the middle of the first pass, then a fresh two-pass layer.
        bus.cfg_num_passes_i  = PC_W'(3);
        bus.cfg_num_windows_i = WC_W'(8);
        bus.cfg_valid_i = 1'b1;
        tick();
        bus.cfg_valid_i = 1'b0;
        tick();
        bus.wgt_ack_i = 1'b1;
        tick();
        bus.wgt_ack_i = 1'b0;
        repeat (2) begin
            set_mon(1'b1);
            tick();
            set_mon(1'b0);
            tick();
        end
        check_eq("midrun_busy", 32'(bus.busy_o), 32'd1);
        dn0 = done_cnt;
        rst_async_n_i = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (2) tick();
        rst_async_n_i = 1'b1;
        tick();
        check_eq("reset_no_done", 32'(done_cnt - dn0), 32'd0);
        run_layer(2, 3, -1);

        check_eq("total_cfg_errs", 32'(err_cnt), 32'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
